// File: rtl/maxpool_window_2x2_pkg.sv
// maxpool_window_2x2_pkg: shared feature-map geometry and sample width for the conv, pool and dense stages
package maxpool_window_2x2_pkg;
   localparam int W1_DEF    = 9;
   localparam int IMG_W_DEF = 26;
   localparam int IMG_H_DEF = 26;
endpackage

// File: rtl/maxpool_window_2x2_if.sv
// maxpool_window_2x2_if: pixel stream in and pooled sample stream out of the pooling stage
interface maxpool_window_2x2_if import maxpool_window_2x2_pkg::*; #(parameter int w1 = W1_DEF) ();
   logic                 in_valid;
   logic signed [w1-1:0] in_data;
   logic                 out_valid;
   logic signed [w1-1:0] out_data;
   logic                 out_last;
   modport master (output in_valid, in_data, input out_valid, out_data, out_last);
   modport slave (input in_valid, in_data, output out_valid, out_data, out_last);
endinterface

// File: rtl/maxpool_window_2x2_max_4.sv
// max_4: combinational signed maximum of four samples
module max_4 #(parameter int w1 = 9) (
   input  logic signed [w1-1:0] num0,
   input  logic signed [w1-1:0] num1,
   input  logic signed [w1-1:0] num2,
   input  logic signed [w1-1:0] num3,
   output logic signed [w1-1:0] max_out
);
   logic signed [w1-1:0] m01, m23;
   // two-level compare tree
   always_comb begin
      m01     = num0 > num1 ? num0 : num1;
      m23     = num2 > num3 ? num2 : num3;
      max_out = m01 > m23 ? m01 : m23;
   end
endmodule

// File: rtl/maxpool_window_2x2.sv
// maxpool_window_2x2: streaming 2x2 stride-2 max pooling with a one-row line buffer
module maxpool_window_2x2 import maxpool_window_2x2_pkg::*; #(
   parameter int w1    = W1_DEF,
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF
) (
   input logic clk,
   input logic rst_n,
   maxpool_window_2x2_if.slave s
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam bit ODD_W = IMG_W % 2 == 1;
   logic [CW-1:0] col, col_even;
   logic [RW-1:0] row;
   logic signed [w1-1:0] linebuf [IMG_W];
   logic signed [w1-1:0] hold, win_max;
   logic last_col, last_row, win, at_last, buf_wr, hold_wr;
   assign last_col = col == CW'(IMG_W - 1);
   assign last_row = row == RW'(IMG_H - 1);
   assign col_even = col & ~CW'(1);
   // odd row and odd col complete a window; floor rule falls out since a trailing odd row/col has even index
   assign win      = s.in_valid & row[0] & col[0];
   assign at_last  = row == RW'(2 * (IMG_H / 2) - 1) && col == CW'(2 * (IMG_W / 2) - 1);
   assign buf_wr   = s.in_valid & ~row[0] & ~(ODD_W & last_col);
   assign hold_wr  = s.in_valid & row[0] & ~col[0];
   max_4 #(.w1(w1)) u_max (
      .num0(linebuf[col_even]),
      .num1(linebuf[col]),
      .num2(hold),
      .num3(s.in_data),
      .max_out(win_max)
   );
   // raster position of the next accepted pixel; frames roll over without a bubble
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (s.in_valid) begin
         col <= last_col ? '0 : col + CW'(1);
         row <= last_col ? (last_row ? '0 : row + RW'(1)) : row;
      end
   // top-row pixels and the left pixel of the bottom pair; always rewritten before read, so no reset
   always_ff @(posedge clk) begin
      if (buf_wr) linebuf[col] <= s.in_data;
      if (hold_wr) hold <= s.in_data;
   end
   // registered pooled sample; out_data holds between pulses
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s.out_valid <= 1'b0;
         s.out_last  <= 1'b0;
         s.out_data  <= '0;
      end else begin
         s.out_valid <= win;
         s.out_last  <= win & at_last;
         if (win) s.out_data <= win_max;
      end
endmodule

// File: tb/tb_maxpool_window_2x2.sv
// tb_maxpool_window_2x2: directed frames on 4x4, 5x5 and 26x26 instances checked against a windowed-max scoreboard
module tb_maxpool_window_2x2;
   import maxpool_window_2x2_pkg::*;
   typedef struct {
      logic signed [8:0] d;
      logic              l;
      int                cyc;
   } exp_t;
   logic clk = 0, rst_n = 0, v = 0;
   logic signed [8:0] d = 0;
   int sel = 0, cyc = 0, nchk = 0, nerr = 0;
   logic ov [3], ol [3];
   logic signed [8:0] od [3];
   exp_t q [3][$];
   int n_out [3] = '{0, 0, 0};
   int n_last [3] = '{0, 0, 0};
   int frame [$];
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : inst
      localparam int W = g == 0 ? 4 : g == 1 ? 5 : 26;
      maxpool_window_2x2_if #(.w1(9)) b ();
      assign b.in_valid = v && sel == g;
      assign b.in_data  = d;
      assign ov[g] = b.out_valid;
      assign od[g] = b.out_data;
      assign ol[g] = b.out_last;
      maxpool_window_2x2 #(.w1(9), .IMG_W(W), .IMG_H(W)) dut (.clk(clk), .rst_n(rst_n), .s(b.slave));
   end
   task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      nchk++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic monitor();
      for (int g = 0; g < 3; g++) begin
         exp_t e;
         bit ev;
         while (q[g].size() > 0 && q[g][0].cyc < cyc) void'(q[g].pop_front());
         ev = q[g].size() > 0 && q[g][0].cyc == cyc;
         chk($sformatf("valid%0d@%0d", g, cyc), ov[g], ev);
         if (ev) begin
            e = q[g].pop_front();
            chk($sformatf("data%0d@%0d", g, cyc), od[g], e.d);
            chk($sformatf("last%0d@%0d", g, cyc), ol[g], e.l);
         end else chk($sformatf("last_idle%0d@%0d", g, cyc), ol[g], 0);
         if (ov[g] === 1'b1) n_out[g]++;
         if (ov[g] === 1'b1 && ol[g] === 1'b1) n_last[g]++;
      end
   endtask
   task automatic step(input int g, input logic vv, input int dd, input bit push, input int ed, input bit el);
      @(posedge clk);
      cyc++;
      #1;
      sel = g;
      v = vv;
      d = dd[8:0];
      if (push) q[g].push_back('{d: ed[8:0], l: el, cyc: cyc + 1});
      @(negedge clk);
      monitor();
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask
   task automatic ramp(input int n, input int base);
      frame.delete();
      for (int i = 0; i < n; i++) frame.push_back(base + i);
   endtask
   task automatic send(input int g, input int w, input int h, input bit gap, input int n);
      for (int k = 0; k < n; k++) begin
         int r, c, m;
         bit p;
         r = k / w;
         c = k % w;
         p = r % 2 == 1 && c % 2 == 1 && r < 2 * (h / 2) && c < 2 * (w / 2);
         m = frame[k];
         if (p) begin
            if (frame[k-1] > m) m = frame[k-1];
            if (frame[k-w] > m) m = frame[k-w];
            if (frame[k-w-1] > m) m = frame[k-w-1];
         end
         step(g, 1, frame[k], p, m, p && r == 2 * (h / 2) - 1 && c == 2 * (w / 2) - 1);
         if (gap) step(g, 0, 0, 0, 0, 0);
      end
   endtask
   initial begin
      #2;
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("rst_valid%0d", g), ov[g], 0);
         chk($sformatf("rst_last%0d", g), ol[g], 0);
         chk($sformatf("rst_data%0d", g), od[g], 0);
      end
      idle(2);
      #1 rst_n = 1;
      ramp(16, 0);
      send(0, 4, 4, 0, 16);
      idle(2);
      frame.delete();
      for (int i = 0; i < 16; i++) frame.push_back(i == 4 ? -3 : -200);
      send(0, 4, 4, 0, 16);
      idle(2);
      ramp(16, 0);
      send(0, 4, 4, 1, 16);
      idle(2);
      ramp(25, 0);
      send(1, 5, 5, 0, 25);
      idle(2);
      frame.delete();
      for (int i = 0; i < 676; i++) frame.push_back(int'($urandom_range(0, 510)) - 256);
      send(2, 26, 26, 0, 676);
      for (int i = 0; i < 676; i++) frame[i] = frame[i] + 1;
      send(2, 26, 26, 0, 676);
      idle(2);
      chk("frames_out", n_out[2], 338);
      chk("frames_last", n_last[2], 2);
      ramp(16, 0);
      send(0, 4, 4, 0, 10);
      #2 rst_n = 0;
      #1;
      chk("mid_rst_data", od[0], 0);
      chk("mid_rst_valid", ov[0], 0);
      chk("mid_rst_last", ol[0], 0);
      q[0].delete();
      idle(3);
      #1 rst_n = 1;
      send(0, 4, 4, 0, 16);
      idle(3);
      for (int g = 0; g < 3; g++) chk($sformatf("drained%0d", g), q[g].size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/maxpool_window_2x2.md
# maxpool_window_2x2

Streaming 2x2/stride-2 max-pooling window stage for one convolution feature map. Accepts the raster-scan pixel stream from the conv/ReLU stage, one signed sample per valid beat. Buffers one image row and assembles each non-overlapping 2x2 window, reducing it with the existing `max_4` comparator. Emits one registered pooled sample per window to the flatten/dense stage.

## Interface
- `w1`, 9: sample width in bits, signed two's complement; input and output use the same width.
- `IMG_W`, 26: feature-map width in pixels; must be ≥ 2.
- `IMG_H`, 26: feature-map height in pixels; must be ≥ 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  `in_data` carries a pixel this cycle; may drop for any number of cycles (gaps allowed); no backpressure.
- `in_data`  in  w1  pixel, signed, raster order (row 0 col 0 first).
- `out_valid`  out  1  `out_data` holds a pooled sample; single-cycle pulse per window.
- `out_data`  out  w1  signed max of the 2x2 window.
- `out_last`  out  1  high with the final pooled sample of a frame.

## Operation
- Counters:
  - `col` runs 0..IMG_W-1 and `row` runs 0..IMG_H-1.
  - Both advance only on cycles where `in_valid` is high.
  - `col` wraps to 0 at IMG_W-1 and `row` increments.
  - At `row`=IMG_H-1, `col`=IMG_W-1 both wrap to 0, so the next frame begins immediately.
- Line buffer:
  - IMG_W entries of w1 bits.
  - On even rows, every accepted pixel is written at index `col`.
- Held register `hold`:
  - On odd rows at even `col`, the accepted pixel is captured in `hold`.
- Window formation:
  - On odd rows at odd `col`, the window is num0=`linebuf[col-1]`, num1=`linebuf[col]`, num2=`hold`, num3=`in_data`.
  - It is reduced by `max_4` and the result is registered.
- Odd sizes: the floor rule applies.
  - If IMG_W is odd, the last column is consumed but produces no window and no buffer write.
  - If IMG_H is odd, the last row is consumed but produces no output.
- Outputs per frame: (IMG_W/2)·(IMG_H/2), integer division. Defaults give 13·13 = 169.
- Comparison is signed. Ties select any equal value, so the result is bit-identical to the maximum.
- Reset mid-frame:
  - `row`, `col`, `out_valid` and `out_last` return to 0 immediately.
  - `out_data` returns to 0.
  - Line buffer and `hold` are not cleared; they are always rewritten before being read.
  - The first pixel after reset is treated as row 0, col 0.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `row`=0, `col`=0.
- Latency: the rising edge that accepts the window-completing pixel (odd row, odd col) sets `out_valid`=1 with `out_data` valid. Output appears one cycle after that pixel is presented.
- `out_valid` is high for exactly one cycle per window. It is low in all other cycles, including gap cycles.
- `out_last` is asserted only together with `out_valid`, on the window completing at row 2·(IMG_H/2)-1, col 2·(IMG_W/2)-1.
- Back-to-back frames:
  - Row 0 of frame N+1 may arrive in the cycle immediately after the last pixel of frame N.
  - No bubble is required, and none is inserted.
- Throughput: one pixel per cycle sustained; at most one output every 2 cycles.
- Input-to-output path: `max_4` is combinational between the input/buffer read and the output register. Line-buffer reads are asynchronous (distributed RAM/registers).

## Structure
- Shared package/header holds the defaults `IMG_W`=26, `IMG_H`=26 and `w1`=9, so that the conv, pool and dense stages agree.
- Single sub-module: an instance of `max_4` (parameter w1 passed through) for the window reduction.
- Everything else is local: counters, line buffer, `hold`, output registers.
- Target size: about 150 RTL lines.

## Test plan
- **Basic 4x4 frame:** IMG_W=IMG_H=4, pixels 0..15 in raster order, continuous valid.
  - Outputs must be 5, 7, 13, 15, one cycle after pixels 5, 7, 13, 15.
  - `out_last` must be high only with 15.
- **Signed values:** 4x4 frame, all pixels -200 except pixel 4 (row 1, col 0) = -3.
  - First output must be -3; all other outputs -200.
  - This must hold for w1=9 signed compare.
- **Input gaps:** 4x4 frame 0..15 with `in_valid` toggling 1,0,1,0.
  - Output values must be identical to the basic frame (5, 7, 13, 15).
  - Each `out_valid` must be the cycle after the completing pixel; none during gaps.
- **Back-to-back frames:** two 26x26 frames with no gap, frame 2 = frame 1 + 1.
  - Must give exactly 169 outputs each, matching a software 2x2 max model.
  - `out_last` must fire exactly twice.
- **Odd dimensions:** IMG_W=5, IMG_H=5, pixels 0..24.
  - Outputs must be exactly 6, 8, 16, 18; `out_last` must be high with 18.
  - Column 4 and row 4 must be ignored.
- **Reset mid-frame:** assert `rst_n`=0 after 10 pixels of a 4x4 frame.
  - Outputs must go to 0 asynchronously.
  - After release, a fresh frame 0..15 must yield 5, 7, 13, 15.
